bbox_sequencer: RTL and testbench
=================================

BBOX_SEQUENCER -- requirements
Module: bbox_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- XCAP_START, 29: run cycle at which X-result bit 8 (MSB) is sampled.
- YCAP_START, 56: run cycle at which Y-result bit 8 (MSB) is sampled.
REQ-002 Ports (name direction width meaning), one per line:
- CLK in 1: single clock; all logic rising-edge.
- RSTN in 1: asynchronous, active-low reset.
- REQ0_VALID in 1: requester 0 has a triangle.
- REQ0_TRI in 54: requester 0 triangle {x1,x2,x3,y1,y2,y3}, 9 bits each, x1 in [53:45].
- REQ0_READY out 1: requester 0 triangle accepted this cycle.
- REQ1_VALID, REQ1_TRI, REQ1_READY: same meaning for requester 1.
- SD out 1: serial data to the bounding-box datapath.
- SEN out 1: shift enable to the bounding-box datapath.
- SXMIN, SXMAX, SYMIN, SYMAX in 1 each: serial results, MSB first.
- OUT_VALID out 1: result held.
- OUT_READY in 1: consumer accepts the result.
- OUT_TAG out 1: requester index of the result.
- OUT_BOX out 36: {XMIN,XMAX,YMIN,YMAX}, 9 bits each.
- BUSY out 1: high in any state except IDLE.

Function
REQ-003 The FSM shall have states IDLE, RUN, DONE. It shall hold at most one triangle in flight.
REQ-004 In IDLE with at least one VALID, the block shall grant one requester:
- One valid: grant that requester.
- Both valid: grant the requester not granted last. The last-grant register resets to 1, so requester 0 wins first.
REQ-005 In the grant cycle:
- Assert REQn_READY for exactly one cycle.
- Latch REQn_TRI and the tag.
- Clear the run counter to 0.
- Go to RUN on the next edge.
REQ-006 READY shall never be asserted outside IDLE. Both READYs shall never be high in the same cycle.
REQ-007 In RUN the 7-bit run counter shall increment once per cycle, starting at cycle 0 (the first RUN cycle).
REQ-008 SEN shall be high for run cycles 0..53 inclusive and low otherwise.
REQ-009 SD shall output the latched triangle MSB first, so run cycle k drives bit [53-k]:
- Cycles 0..26 carry x1, x2, x3.
- Cycles 27..53 carry y1, y2, y3.
- SD shall be 0 whenever SEN is low.
REQ-010 Result capture (j = 0..8):
- At run cycle XCAP_START+j, sample SXMIN into XMIN[8-j] and SXMAX into XMAX[8-j].
- At run cycle YCAP_START+j, sample SYMIN into YMIN[8-j] and SYMAX into YMAX[8-j].
REQ-011 RUN shall end after run cycle LAST = max(53, XCAP_START+8, YCAP_START+8), then go to DONE. With defaults LAST = 64, so RUN lasts 65 cycles.
REQ-012 In DONE:
- OUT_VALID shall be high and OUT_BOX and OUT_TAG stable.
- When OUT_VALID and OUT_READY are both high at an edge, go to IDLE.
- OUT_READY while not in DONE shall be ignored.
REQ-013 A new grant may occur in the first IDLE cycle after DONE. Minimum grant-to-grant spacing is LAST+3 cycles.
REQ-014 A requester deasserting VALID or changing TRI after its READY cycle shall not affect the run in flight.
REQ-015 VALID deasserted before grant is legal. The request is simply not granted.
REQ-016 The run counter shall not wrap. Parameters shall satisfy XCAP_START+8 <= 126 and YCAP_START+8 <= 126.
REQ-017 Both requesters valid continuously shall alternate grants 0,1,0,1,...

Reset
REQ-018 When RSTN=0, asynchronously:
- FSM = IDLE; run counter = 0; last-grant = 1.
- SD = SEN = OUT_VALID = OUT_TAG = BUSY = 0; READYs = 0.
- OUT_BOX and the latched triangle = 0.
REQ-019 Reset asserted mid-RUN or in DONE shall abandon the triangle with no OUT_VALID pulse. The first grant after release follows REQ-004 with last-grant = 1.
REQ-020 After reset deassertion, the first grant may occur on the first rising edge with RSTN high.

Verification
REQ-021 Single request, REQ0_TRI = {9'd10,9'd200,9'd50,9'd7,9'd300,9'd90}, datapath model connected:
- OUT_VALID rises 66 cycles after the grant edge.
- OUT_BOX = {10,200,7,300}, OUT_TAG = 0.
REQ-022 Serial stream check on the same triangle:
- SEN high for exactly 54 consecutive cycles.
- SD cycles 0..8 = 000001010 (x1=10).
- SD cycles 27..35 = 000000111 (y1=7).
REQ-023 REQ0_VALID and REQ1_VALID held high with 4 results accepted:
- Tags 0,1,0,1.
- READY pulses exactly one cycle each; never both high in one cycle.
REQ-024 OUT_READY held low for 20 cycles in DONE:
- OUT_VALID and OUT_BOX stay stable.
- No READY asserted.
- One cycle after OUT_READY rises: IDLE, BUSY = 0.
REQ-025 RSTN pulsed low at run cycle 30:
- All outputs 0 immediately.
- No OUT_VALID.
- Next simultaneous request is granted to requester 0.
REQ-026 Degenerate triangle with all coordinates 9'd511: OUT_BOX = {511,511,511,511}.

Source files
------------

// File: rtl/bbox_sequencer.sv
// Arbitrates two triangle requesters onto a serial bounding-box datapath, streams the
// selected triangle MSB first, deserialises the min/max results and holds them for the consumer.
module bbox_sequencer #(
    parameter int XCAP_START = 29,
    parameter int YCAP_START = 56
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        REQ0_VALID,
    input  logic [53:0] REQ0_TRI,
    output logic        REQ0_READY,
    input  logic        REQ1_VALID,
    input  logic [53:0] REQ1_TRI,
    output logic        REQ1_READY,
    output logic        SD,
    output logic        SEN,
    input  logic        SXMIN,
    input  logic        SXMAX,
    input  logic        SYMIN,
    input  logic        SYMAX,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        OUT_TAG,
    output logic [35:0] OUT_BOX,
    output logic        BUSY
);

    localparam int XCAP_LAST = XCAP_START + 8;
    localparam int YCAP_LAST = YCAP_START + 8;
    localparam int CAP_LAST  = (XCAP_LAST > YCAP_LAST) ? XCAP_LAST : YCAP_LAST;
    localparam int LAST      = (CAP_LAST > 53) ? CAP_LAST : 53;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic [53:0] tri_q, tri_d;
    logic        tag_q, tag_d;
    logic [35:0] box_q, box_d;

    logic grant_any;
    logic grant_idx;

    // Round-robin only matters on a tie; a lone requester always wins.
    assign grant_any = REQ0_VALID | REQ1_VALID;
    assign grant_idx = (REQ0_VALID & REQ1_VALID) ? ~last_q : REQ1_VALID;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            tri_q   <= '0;
            tag_q   <= 1'b0;
            box_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            tri_q   <= tri_d;
            tag_q   <= tag_d;
            box_q   <= box_d;
        end
    end

    // NOTE: every signal gets a hold default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        tri_d   = tri_q;
        tag_d   = tag_q;
        box_d   = box_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    tri_d   = grant_idx ? REQ1_TRI : REQ0_TRI;
                    tag_d   = grant_idx;
                    last_d  = grant_idx;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 7'd1;
                // The triangle register doubles as the serialiser: bit 53 is always on SD.
                if (cnt_q <= 7'd53) begin
                    tri_d = {tri_q[52:0], 1'b0};
                end
                for (int j = 0; j < 9; j++) begin
                    if (cnt_q == 7'(XCAP_START + j)) begin
                        box_d[35-j] = SXMIN;
                        box_d[26-j] = SXMAX;
                    end
                    if (cnt_q == 7'(YCAP_START + j)) begin
                        box_d[17-j] = SYMIN;
                        box_d[8-j]  = SYMAX;
                    end
                end
                if (cnt_q == 7'(LAST)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        SEN        = (state_q == RUN) && (cnt_q <= 7'd53);
        SD         = SEN & tri_q[53];
        OUT_VALID  = (state_q == DONE);
        BUSY       = (state_q != IDLE);
        // Gated by RSTN so a requester never sees READY while the block is held in reset.
        REQ0_READY = RSTN & (state_q == IDLE) & grant_any & ~grant_idx;
        REQ1_READY = RSTN & (state_q == IDLE) & grant_any & grant_idx;
    end

    assign OUT_TAG = tag_q;
    assign OUT_BOX = box_q;

endmodule

// File: tb/tb_bbox_sequencer.sv
// Directed bench for bbox_sequencer with a behavioural serial min/max datapath attached.
module tb_bbox_sequencer;

    localparam logic [53:0] T1    = {9'd10, 9'd200, 9'd50, 9'd7, 9'd300, 9'd90};
    localparam logic [35:0] BOX1  = {9'd10, 9'd200, 9'd7, 9'd300};
    localparam logic [53:0] TA    = {9'd100, 9'd20, 9'd300, 9'd5, 9'd400, 9'd250};
    localparam logic [35:0] BOXA  = {9'd20, 9'd300, 9'd5, 9'd400};
    localparam logic [53:0] TB    = {9'd0, 9'd511, 9'd256, 9'd128, 9'd127, 9'd129};
    localparam logic [35:0] BOXB  = {9'd0, 9'd511, 9'd127, 9'd129};
    localparam logic [53:0] JUNK  = 54'h2A_AAAA_AAAA_AAAA;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        REQ0_VALID, REQ1_VALID;
    logic [53:0] REQ0_TRI, REQ1_TRI;
    logic        REQ0_READY, REQ1_READY;
    logic        SD, SEN;
    logic        SXMIN, SXMAX, SYMIN, SYMAX;
    logic        OUT_VALID, OUT_READY, OUT_TAG, BUSY;
    logic [35:0] OUT_BOX;

    always #5 CLK = ~CLK;

    bbox_sequencer dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .REQ0_VALID(REQ0_VALID),
        .REQ0_TRI  (REQ0_TRI),
        .REQ0_READY(REQ0_READY),
        .REQ1_VALID(REQ1_VALID),
        .REQ1_TRI  (REQ1_TRI),
        .REQ1_READY(REQ1_READY),
        .SD        (SD),
        .SEN       (SEN),
        .SXMIN     (SXMIN),
        .SXMAX     (SXMAX),
        .SYMIN     (SYMIN),
        .SYMAX     (SYMAX),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_TAG   (OUT_TAG),
        .OUT_BOX   (OUT_BOX),
        .BUSY      (BUSY)
    );

    // Datapath model: deserialise x after 27 bits, y after 54, replay results MSB first.
    function automatic logic [8:0] min3(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c);
        logic [8:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [8:0] max3(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c);
        logic [8:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    logic [6:0]  mk = '0;
    logic [53:0] sr = '0;
    logic [8:0]  xmin_m = '0, xmax_m = '0, ymin_m = '0, ymax_m = '0;
    wire  [53:0] sr_n = {sr[52:0], SD};

    always @(posedge CLK) begin
        if (!BUSY) mk <= '0;
        else       mk <= mk + 7'd1;
        if (SEN) sr <= sr_n;
        if (BUSY && SEN && mk == 7'd26) begin
            xmin_m <= min3(sr_n[26:18], sr_n[17:9], sr_n[8:0]);
            xmax_m <= max3(sr_n[26:18], sr_n[17:9], sr_n[8:0]);
        end
        if (BUSY && SEN && mk == 7'd53) begin
            ymin_m <= min3(sr_n[26:18], sr_n[17:9], sr_n[8:0]);
            ymax_m <= max3(sr_n[26:18], sr_n[17:9], sr_n[8:0]);
        end
    end

    always_comb begin
        int xi;
        int yi;
        xi = 37 - int'(mk);
        yi = 64 - int'(mk);
        SXMIN = 1'b0;
        SXMAX = 1'b0;
        SYMIN = 1'b0;
        SYMAX = 1'b0;
        if (xi >= 0 && xi <= 8) begin
            SXMIN = xmin_m[xi[3:0]];
            SXMAX = xmax_m[xi[3:0]];
        end
        if (yi >= 0 && yi <= 8) begin
            SYMIN = ymin_m[yi[3:0]];
            SYMAX = ymax_m[yi[3:0]];
        end
    end

    // Free-running monitors sampled on the falling edge; the sequence reads differences.
    int          r0_cyc = 0, r1_cyc = 0, both_cyc = 0, rdy_busy_cyc = 0;
    int          sen_cyc = 0, sen_rise = 0, ov_cyc = 0;
    logic        sen_prev = 1'b0;
    logic [53:0] sd_log = '0;

    always @(negedge CLK) begin
        if (REQ0_READY)                        r0_cyc       <= r0_cyc + 1;
        if (REQ1_READY)                        r1_cyc       <= r1_cyc + 1;
        if (REQ0_READY && REQ1_READY)          both_cyc     <= both_cyc + 1;
        if ((REQ0_READY || REQ1_READY) && BUSY) rdy_busy_cyc <= rdy_busy_cyc + 1;
        if (OUT_VALID)                         ov_cyc       <= ov_cyc + 1;
        if (SEN) begin
            sen_cyc <= sen_cyc + 1;
            sd_log  <= {sd_log[52:0], SD};
        end
        if (SEN && !sen_prev) sen_rise <= sen_rise + 1;
        sen_prev <= SEN;
    end

    int checks = 0;
    int passed = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!OUT_VALID && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int r0b, r1b, bothb, rbb, senb, riseb, ovb;

        RSTN       = 1'b1;
        REQ0_VALID = 1'b1;
        REQ1_VALID = 1'b1;
        REQ0_TRI   = '0;
        REQ1_TRI   = '0;
        OUT_READY  = 1'b0;
        #1 RSTN    = 1'b0;
        tick();
        tick();
        check("rst_ready0", REQ0_READY, 0);
        check("rst_ready1", REQ1_READY, 0);
        check("rst_sd", SD, 0);
        check("rst_sen", SEN, 0);
        check("rst_out_valid", OUT_VALID, 0);
        check("rst_out_tag", OUT_TAG, 0);
        check("rst_out_box", OUT_BOX, 0);
        check("rst_busy", BUSY, 0);

        // Single request from requester 0, granted on the first edge after release.
        REQ1_VALID = 1'b0;
        REQ0_TRI   = T1;
        senb       = sen_cyc;
        riseb      = sen_rise;
        RSTN       = 1'b1;
        #1;
        check("t1_ready0", REQ0_READY, 1);
        check("t1_ready1", REQ1_READY, 0);
        tick();
        REQ0_VALID = 1'b0;
        REQ0_TRI   = JUNK;
        #1;
        check("t1_busy", BUSY, 1);
        check("t1_ready0_after_grant", REQ0_READY, 0);
        wait_done(c);
        check("t1_latency", c + 1, 66);
        check("t1_out_valid", OUT_VALID, 1);
        check("t1_box", OUT_BOX, BOX1);
        check("t1_tag", OUT_TAG, 0);
        check("t1_sen_cycles", sen_cyc - senb, 54);
        check("t1_sen_bursts", sen_rise - riseb, 1);
        check("t1_sd_x1", sd_log[53:45], 9'd10);
        check("t1_sd_y1", sd_log[26:18], 9'd7);
        check("t1_sd_stream", sd_log, T1);

        // Hold the result for 20 cycles with a competing request pending.
        REQ0_VALID = 1'b1;
        REQ0_TRI   = TA;
        r0b        = r0_cyc + r1_cyc;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("stall_out_valid", OUT_VALID, 1);
            check("stall_box", OUT_BOX, BOX1);
            check("stall_tag", OUT_TAG, 0);
        end
        check("stall_no_ready", r0_cyc + r1_cyc - r0b, 0);
        REQ0_VALID = 1'b0;
        OUT_READY  = 1'b1;
        #1;
        check("stall_release_valid", OUT_VALID, 1);
        tick();
        OUT_READY = 1'b0;
        check("stall_idle_busy", BUSY, 0);
        check("stall_idle_valid", OUT_VALID, 0);

        // Degenerate triangle from requester 1.
        REQ1_VALID = 1'b1;
        REQ1_TRI   = '1;
        #1;
        check("deg_ready1", REQ1_READY, 1);
        check("deg_ready0", REQ0_READY, 0);
        tick();
        REQ1_VALID = 1'b0;
        wait_done(c);
        check("deg_done", OUT_VALID, 1);
        check("deg_box", OUT_BOX, {4{9'd511}});
        check("deg_tag", OUT_TAG, 1);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;

        // Both requesters held valid: grants must alternate starting from requester 0.
        r0b        = r0_cyc;
        r1b        = r1_cyc;
        bothb      = both_cyc;
        rbb        = rdy_busy_cyc;
        REQ0_TRI   = TA;
        REQ1_TRI   = TB;
        REQ0_VALID = 1'b1;
        REQ1_VALID = 1'b1;
        OUT_READY  = 1'b1;
        for (int n = 0; n < 4; n++) begin
            wait_done(c);
            check("alt_done", OUT_VALID, 1);
            check("alt_tag", OUT_TAG, n % 2);
            check("alt_box", OUT_BOX, (n % 2 == 1) ? BOXB : BOXA);
            if (n == 3) begin
                REQ0_VALID = 1'b0;
                REQ1_VALID = 1'b0;
            end
            tick();
        end
        OUT_READY = 1'b0;
        tick();
        check("alt_ready0_cycles", r0_cyc - r0b, 2);
        check("alt_ready1_cycles", r1_cyc - r1b, 2);
        check("alt_both_ready", both_cyc - bothb, 0);
        check("alt_ready_while_busy", rdy_busy_cyc - rbb, 0);
        check("alt_idle", BUSY, 0);

        // Reset in run cycle 30 abandons the triangle; the tie after release goes to requester 0.
        REQ0_VALID = 1'b1;
        REQ0_TRI   = TA;
        ovb        = ov_cyc;
        #1;
        check("rr_ready0", REQ0_READY, 1);
        tick();
        REQ0_VALID = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("rr_busy_c30", BUSY, 1);
        check("rr_sen_c30", SEN, 1);
        RSTN       = 1'b0;
        REQ0_VALID = 1'b1;
        REQ1_VALID = 1'b1;
        #1;
        check("rr_busy", BUSY, 0);
        check("rr_sen", SEN, 0);
        check("rr_sd", SD, 0);
        check("rr_out_valid", OUT_VALID, 0);
        check("rr_out_tag", OUT_TAG, 0);
        check("rr_out_box", OUT_BOX, 0);
        check("rr_ready0", REQ0_READY, 0);
        check("rr_ready1", REQ1_READY, 0);
        tick();
        tick();
        check("rr_no_out_valid", ov_cyc - ovb, 0);
        RSTN = 1'b1;
        #1;
        check("rr_grant0", REQ0_READY, 1);
        check("rr_grant1", REQ1_READY, 0);
        tick();
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        wait_done(c);
        check("rr_done", OUT_VALID, 1);
        check("rr_tag", OUT_TAG, 0);
        check("rr_box", OUT_BOX, BOXA);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        check("rr_final_idle", BUSY, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
